// File: rtl/roi_pkt_fifo_pkg.sv
// Shared types and defaults for the ROI packet FIFO and its neighbours.
package roi_pkt_fifo_pkg;

   localparam int BIT_DATA_DEF = 8;

   typedef enum logic {
      PASS = 1'b0,
      DROP = 1'b1
   } fifo_state_t;

endpackage

// File: rtl/roi_pkt_fifo_if.sv
// Stream bundle around the packet FIFO: gapped crop input (no ready) and AXIS output.
interface roi_pkt_fifo_if
   import roi_pkt_fifo_pkg::*;
#(
   parameter int BIT_DATA = BIT_DATA_DEF
);

   logic [BIT_DATA-1:0] s_tdata_i;
   logic                s_tvalid_i;
   logic                s_tlast_i;
   logic [BIT_DATA-1:0] m_tdata_o;
   logic                m_tvalid_o;
   logic                m_tready_i;
   logic                m_tlast_o;

   // Driving side: crop stage plus downstream sink.
   modport master (
      output s_tdata_i, s_tvalid_i, s_tlast_i, m_tready_i,
      input  m_tdata_o, m_tvalid_o, m_tlast_o
   );

   // The FIFO itself.
   modport slave (
      input  s_tdata_i, s_tvalid_i, s_tlast_i, m_tready_i,
      output m_tdata_o, m_tvalid_o, m_tlast_o
   );

endinterface

// File: rtl/roi_pkt_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module roi_pkt_fifo_sdp_ram #(
   parameter int BIT_W = 9,
   parameter int DEPTH = 1024
) (
   input  logic                     clk_i,
   input  logic                     i_wr_en,
   input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
   input  logic [BIT_W-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
   output logic [BIT_W-1:0]         o_rd_data
);

   logic [BIT_W-1:0] r_mem [DEPTH];
   logic [BIT_W-1:0] r_rd_data;

   always_ff @(posedge clk_i) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/roi_pkt_fifo.sv
// Store-and-forward packet FIFO behind the ROI crop stage; overflowing packets are dropped whole.
module roi_pkt_fifo
   import roi_pkt_fifo_pkg::*;
#(
   parameter int BIT_DATA = BIT_DATA_DEF,
   parameter int DEPTH    = 1024,
   parameter int BIT_CNT  = 16
) (
   input  logic                   clk_i,
   input  logic                   arst_i,
   roi_pkt_fifo_if.slave          axis,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   ovf_o,
   input  logic                   ovf_clr_i,
   output logic [BIT_CNT-1:0]     pkt_cnt_o,
   output logic [BIT_CNT-1:0]     drop_cnt_o
);

   localparam int BIT_ADDR = $clog2(DEPTH);
   localparam int BIT_PTR  = BIT_ADDR + 1;
   localparam logic [BIT_PTR-1:0] PTR_ONE   = BIT_PTR'(1);
   localparam logic [BIT_PTR-1:0] PTR_DEPTH = BIT_PTR'(DEPTH);

   fifo_state_t         r_state, w_state_nxt;
   logic [BIT_PTR-1:0]  r_wr_ptr, r_wr_cmt, r_rd_ptr, r_pf_ptr;
   logic [BIT_PTR-1:0]  w_wr_ptr_nxt, w_wr_cmt_nxt;
   logic                w_full, w_wr_en, w_drop;
   logic                w_rd_en, w_out_free, w_accept;
   logic                r_ram_vld;
   logic [BIT_DATA:0]   w_ram_rd;
   logic                r_m_tvalid, r_m_tlast;
   logic [BIT_DATA-1:0] r_m_tdata;
   logic                r_ovf;
   logic [BIT_CNT-1:0]  r_pkt_cnt, r_drop_cnt;

   // Space is measured against accepted beats, so prefetched slots are never overwritten.
   assign w_full = (r_wr_ptr - r_rd_ptr) == PTR_DEPTH;

   always_comb begin
      w_state_nxt  = r_state;
      w_wr_en      = 1'b0;
      w_drop       = 1'b0;
      w_wr_ptr_nxt = r_wr_ptr;
      w_wr_cmt_nxt = r_wr_cmt;
      case (r_state)
         PASS: begin
            if (axis.s_tvalid_i) begin
               if (!w_full) begin
                  w_wr_en      = 1'b1;
                  w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                  if (axis.s_tlast_i) w_wr_cmt_nxt = r_wr_ptr + PTR_ONE;
               end else begin
                  w_drop       = 1'b1;
                  w_wr_ptr_nxt = r_wr_cmt;
                  if (!axis.s_tlast_i) w_state_nxt = DROP;
               end
            end
         end
         DROP: begin
            if (axis.s_tvalid_i && axis.s_tlast_i) w_state_nxt = PASS;
         end
         default: w_state_nxt = PASS;
      endcase
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_state  <= PASS;
         r_wr_ptr <= '0;
         r_wr_cmt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_wr_ptr <= w_wr_ptr_nxt;
         r_wr_cmt <= w_wr_cmt_nxt;
      end
   end

   roi_pkt_fifo_sdp_ram #(
      .BIT_W (BIT_DATA + 1),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk_i     (clk_i),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_wr_ptr[BIT_ADDR-1:0]),
      .i_wr_data ({axis.s_tlast_i, axis.s_tdata_i}),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (r_pf_ptr[BIT_ADDR-1:0]),
      .o_rd_data (w_ram_rd)
   );

   // Two-slot read pipeline: RAM read register then output register.
   assign w_accept   = r_m_tvalid & axis.m_tready_i;
   assign w_out_free = !r_m_tvalid | axis.m_tready_i;
   assign w_rd_en    = (r_pf_ptr != r_wr_cmt) & (!r_ram_vld | w_out_free);

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_pf_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_ram_vld  <= 1'b0;
         r_m_tvalid <= 1'b0;
         r_m_tlast  <= 1'b0;
         r_m_tdata  <= '0;
         r_ovf      <= 1'b0;
         r_pkt_cnt  <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_rd_en)  r_pf_ptr <= r_pf_ptr + PTR_ONE;
         if (w_accept) r_rd_ptr <= r_rd_ptr + PTR_ONE;
         r_ram_vld <= w_rd_en | (r_ram_vld & !w_out_free);
         if (w_out_free) r_m_tvalid <= r_ram_vld;
         if (w_out_free && r_ram_vld) begin
            r_m_tdata <= w_ram_rd[BIT_DATA-1:0];
            r_m_tlast <= w_ram_rd[BIT_DATA];
         end
         if (w_drop)         r_ovf <= 1'b1;
         else if (ovf_clr_i) r_ovf <= 1'b0;
         if (w_accept && r_m_tlast) r_pkt_cnt <= r_pkt_cnt + BIT_CNT'(1);
         if (w_drop)                r_drop_cnt <= r_drop_cnt + BIT_CNT'(1);
      end
   end

   assign axis.m_tdata_o  = r_m_tdata;
   assign axis.m_tvalid_o = r_m_tvalid;
   assign axis.m_tlast_o  = r_m_tlast;
   assign level_o         = r_wr_cmt - r_rd_ptr;
   assign ovf_o           = r_ovf;
   assign pkt_cnt_o       = r_pkt_cnt;
   assign drop_cnt_o      = r_drop_cnt;

endmodule

// File: tb/tb_roi_pkt_fifo.sv
// Directed bench for roi_pkt_fifo with DEPTH=16; output beats are logged by a monitor.
module tb_roi_pkt_fifo;

   logic        clk;
   logic        arst;
   logic        ovf_clr;
   logic [4:0]  level;
   logic        ovf;
   logic [15:0] pkt_cnt;
   logic [15:0] drop_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   logic [8:0] q_beat[$];
   int         q_cyc[$];

   roi_pkt_fifo_if #(.BIT_DATA(8)) axis_if ();

   roi_pkt_fifo #(
      .BIT_DATA (8),
      .DEPTH    (16),
      .BIT_CNT  (16)
   ) dut (
      .clk_i      (clk),
      .arst_i     (arst),
      .axis       (axis_if.slave),
      .level_o    (level),
      .ovf_o      (ovf),
      .ovf_clr_i  (ovf_clr),
      .pkt_cnt_o  (pkt_cnt),
      .drop_cnt_o (drop_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // A beat seen valid&ready at the negedge is handshaked at the following posedge.
   always @(negedge clk) begin
      if (!arst && axis_if.m_tvalid_o && axis_if.m_tready_i) begin
         q_beat.push_back({axis_if.m_tlast_o, axis_if.m_tdata_o});
         q_cyc.push_back(cyc);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      arst = 1'b1;
      axis_if.s_tvalid_i = 1'b0;
      axis_if.s_tlast_i  = 1'b0;
      axis_if.s_tdata_i  = 8'h00;
      axis_if.m_tready_i = 1'b0;
      ovf_clr = 1'b0;
      step(2);
      arst = 1'b0;
      q_beat.delete();
      q_cyc.delete();
   endtask

   task automatic send_pkt(input logic [7:0] base, input int n, input bit with_last);
      for (int i = 0; i < n; i++) begin
         axis_if.s_tvalid_i = 1'b1;
         axis_if.s_tdata_i  = base + 8'(i);
         axis_if.s_tlast_i  = with_last && (i == n - 1);
         step(1);
      end
      axis_if.s_tvalid_i = 1'b0;
      axis_if.s_tlast_i  = 1'b0;
      axis_if.s_tdata_i  = 8'h00;
   endtask

   task automatic wait_q(input int n);
      for (int i = 0; i < 300; i++) begin
         if (q_beat.size() >= n) break;
         step(1);
      end
   endtask

   task automatic test_reset();
      do_reset();
      arst = 1'b1;
      #2;
      n_checks++;
      if ({axis_if.m_tvalid_o, axis_if.m_tlast_o, axis_if.m_tdata_o} !== 10'h000) begin
         n_errors++;
         $display("FAIL reset_axis got %h exp 000", {axis_if.m_tvalid_o, axis_if.m_tlast_o, axis_if.m_tdata_o});
      end
      n_checks++;
      if ({level, ovf, pkt_cnt, drop_cnt} !== 38'h0) begin
         n_errors++;
         $display("FAIL reset_status got %h exp 0", {level, ovf, pkt_cnt, drop_cnt});
      end
      do_reset();
   endtask

   task automatic test_basic();
      logic [8:0] exp;
      do_reset();
      axis_if.m_tready_i = 1'b1;
      send_pkt(8'h11, 4, 1'b1);
      n_checks++;
      if (axis_if.m_tvalid_o !== 1'b0) begin
         n_errors++;
         $display("FAIL lat_e0 got %b exp 0", axis_if.m_tvalid_o);
      end
      step(1);
      n_checks++;
      if (axis_if.m_tvalid_o !== 1'b0) begin
         n_errors++;
         $display("FAIL lat_e1 got %b exp 0", axis_if.m_tvalid_o);
      end
      step(1);
      n_checks++;
      if ({axis_if.m_tvalid_o, axis_if.m_tdata_o} !== 9'h111) begin
         n_errors++;
         $display("FAIL lat_e2 got %h exp 111", {axis_if.m_tvalid_o, axis_if.m_tdata_o});
      end
      wait_q(4);
      step(3);
      n_checks++;
      if (q_beat.size() !== 4) begin
         n_errors++;
         $display("FAIL basic_count got %0d exp 4", q_beat.size());
      end
      for (int i = 0; i < 4 && i < q_beat.size(); i++) begin
         exp = {i == 3, 8'h11 + 8'(i)};
         n_checks++;
         if (q_beat[i] !== exp) begin
            n_errors++;
            $display("FAIL basic_beat%0d got %h exp %h", i, q_beat[i], exp);
         end
      end
      n_checks++;
      if ({pkt_cnt, level} !== {16'd1, 5'd0}) begin
         n_errors++;
         $display("FAIL basic_cnt pkt %0d level %0d exp 1 0", pkt_cnt, level);
      end
   endtask

   task automatic test_stall();
      logic [8:0] exp;
      bit held;
      do_reset();
      send_pkt(8'h11, 4, 1'b1);
      for (int i = 0; i < 10; i++) begin
         if (axis_if.m_tvalid_o) break;
         step(1);
      end
      held = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (!(axis_if.m_tvalid_o === 1'b1 && axis_if.m_tdata_o === 8'h11 && axis_if.m_tlast_o === 1'b0))
            held = 1'b0;
         step(1);
      end
      n_checks++;
      if (held !== 1'b1) begin
         n_errors++;
         $display("FAIL stall_hold got %b exp 1 (last tdata %h)", held, axis_if.m_tdata_o);
      end
      axis_if.m_tready_i = 1'b1;
      wait_q(4);
      step(5);
      n_checks++;
      if (q_beat.size() !== 4) begin
         n_errors++;
         $display("FAIL stall_count got %0d exp 4", q_beat.size());
      end
      for (int i = 0; i < 4 && i < q_beat.size(); i++) begin
         exp = {i == 3, 8'h11 + 8'(i)};
         n_checks++;
         if (q_beat[i] !== exp) begin
            n_errors++;
            $display("FAIL stall_beat%0d got %h exp %h", i, q_beat[i], exp);
         end
      end
   endtask

   task automatic test_overflow();
      logic [8:0] exp;
      do_reset();
      send_pkt(8'h20, 10, 1'b1);
      send_pkt(8'h40, 8, 1'b1);
      step(2);
      n_checks++;
      if ({ovf, drop_cnt, level, pkt_cnt} !== {1'b1, 16'd1, 5'd10, 16'd0}) begin
         n_errors++;
         $display("FAIL ovf_status ovf %b drop %0d level %0d pkt %0d exp 1 1 10 0", ovf, drop_cnt, level, pkt_cnt);
      end
      axis_if.m_tready_i = 1'b1;
      wait_q(10);
      step(8);
      n_checks++;
      if (q_beat.size() !== 10) begin
         n_errors++;
         $display("FAIL ovf_count got %0d exp 10", q_beat.size());
      end
      for (int i = 0; i < 10 && i < q_beat.size(); i++) begin
         exp = {i == 9, 8'h20 + 8'(i)};
         n_checks++;
         if (q_beat[i] !== exp) begin
            n_errors++;
            $display("FAIL ovf_beat%0d got %h exp %h", i, q_beat[i], exp);
         end
      end
      n_checks++;
      if ({pkt_cnt, level} !== {16'd1, 5'd0}) begin
         n_errors++;
         $display("FAIL ovf_drain pkt %0d level %0d exp 1 0", pkt_cnt, level);
      end
   endtask

   task automatic test_full_single();
      logic [8:0] exp;
      do_reset();
      send_pkt(8'h60, 16, 1'b1);
      step(2);
      n_checks++;
      if ({level, ovf} !== {5'd16, 1'b0}) begin
         n_errors++;
         $display("FAIL full_level level %0d ovf %b exp 16 0", level, ovf);
      end
      ovf_clr = 1'b1;
      send_pkt(8'h99, 1, 1'b1);
      ovf_clr = 1'b0;
      n_checks++;
      if ({ovf, drop_cnt, level} !== {1'b1, 16'd1, 5'd16}) begin
         n_errors++;
         $display("FAIL full_drop ovf %b drop %0d level %0d exp 1 1 16", ovf, drop_cnt, level);
      end
      ovf_clr = 1'b1;
      step(1);
      ovf_clr = 1'b0;
      n_checks++;
      if (ovf !== 1'b0) begin
         n_errors++;
         $display("FAIL ovf_clear got %b exp 0", ovf);
      end
      axis_if.m_tready_i = 1'b1;
      wait_q(16);
      send_pkt(8'hA0, 3, 1'b1);
      wait_q(19);
      step(6);
      n_checks++;
      if (q_beat.size() !== 19) begin
         n_errors++;
         $display("FAIL full_count got %0d exp 19", q_beat.size());
      end
      for (int i = 0; i < 19 && i < q_beat.size(); i++) begin
         exp = (i < 16) ? {i == 15, 8'h60 + 8'(i)} : {i == 18, 8'hA0 + 8'(i - 16)};
         n_checks++;
         if (q_beat[i] !== exp) begin
            n_errors++;
            $display("FAIL full_beat%0d got %h exp %h", i, q_beat[i], exp);
         end
      end
      n_checks++;
      if ({pkt_cnt, drop_cnt} !== {16'd2, 16'd1}) begin
         n_errors++;
         $display("FAIL full_cnt pkt %0d drop %0d exp 2 1", pkt_cnt, drop_cnt);
      end
   endtask

   task automatic test_gapped();
      logic [8:0] exp;
      do_reset();
      axis_if.m_tready_i = 1'b1;
      send_pkt(8'h31, 3, 1'b0);
      step(797);
      n_checks++;
      if (q_beat.size() !== 0 || axis_if.m_tvalid_o !== 1'b0) begin
         n_errors++;
         $display("FAIL gap_early got %0d beats valid %b exp 0 0", q_beat.size(), axis_if.m_tvalid_o);
      end
      send_pkt(8'h34, 3, 1'b1);
      wait_q(6);
      step(4);
      n_checks++;
      if (q_beat.size() !== 6) begin
         n_errors++;
         $display("FAIL gap_count got %0d exp 6", q_beat.size());
      end
      for (int i = 0; i < 6 && i < q_beat.size(); i++) begin
         exp = {i == 5, 8'h31 + 8'(i)};
         n_checks++;
         if (q_beat[i] !== exp || q_cyc[i] !== q_cyc[0] + i) begin
            n_errors++;
            $display("FAIL gap_beat%0d got %h at +%0d exp %h at +%0d", i, q_beat[i], q_cyc[i] - q_cyc[0], exp, i);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [8:0] exp;
      do_reset();
      send_pkt(8'hE1, 2, 1'b1);
      send_pkt(8'h50, 5, 1'b0);
      n_checks++;
      if ({axis_if.m_tvalid_o, axis_if.m_tdata_o, level} !== {1'b1, 8'hE1, 5'd2}) begin
         n_errors++;
         $display("FAIL pre_rst valid %b data %h level %0d exp 1 e1 2", axis_if.m_tvalid_o, axis_if.m_tdata_o, level);
      end
      arst = 1'b1;
      #2;
      n_checks++;
      if ({axis_if.m_tvalid_o, axis_if.m_tlast_o, axis_if.m_tdata_o, level, ovf, pkt_cnt, drop_cnt} !== 48'h0) begin
         n_errors++;
         $display("FAIL mid_rst_out valid %b data %h level %0d exp all 0", axis_if.m_tvalid_o, axis_if.m_tdata_o, level);
      end
      step(2);
      arst = 1'b0;
      q_beat.delete();
      q_cyc.delete();
      axis_if.m_tready_i = 1'b1;
      send_pkt(8'h70, 4, 1'b1);
      wait_q(4);
      step(6);
      n_checks++;
      if (q_beat.size() !== 4) begin
         n_errors++;
         $display("FAIL mid_rst_count got %0d exp 4", q_beat.size());
      end
      for (int i = 0; i < 4 && i < q_beat.size(); i++) begin
         exp = {i == 3, 8'h70 + 8'(i)};
         n_checks++;
         if (q_beat[i] !== exp) begin
            n_errors++;
            $display("FAIL mid_rst_beat%0d got %h exp %h", i, q_beat[i], exp);
         end
      end
      n_checks++;
      if ({pkt_cnt, ovf, drop_cnt} !== {16'd1, 1'b0, 16'd0}) begin
         n_errors++;
         $display("FAIL mid_rst_cnt pkt %0d ovf %b drop %0d exp 1 0 0", pkt_cnt, ovf, drop_cnt);
      end
   endtask

   initial begin
      arst = 1'b1;
      ovf_clr = 1'b0;
      axis_if.s_tvalid_i = 1'b0;
      axis_if.s_tlast_i  = 1'b0;
      axis_if.s_tdata_i  = 8'h00;
      axis_if.m_tready_i = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_stall();
      test_overflow();
      test_full_single();
      test_gapped();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
